// File: rtl/prelude_pkg.sv
// Shared types and constants for the Prelude CPU:
// instruction classes, ALU ops, branch conditions, FSM states.
package prelude_pkg;

    typedef enum logic [1:0] {
        CLS_IMM    = 2'b00,
        CLS_CALC   = 2'b01,
        CLS_COPY   = 2'b10,
        CLS_BRANCH = 2'b11
    } cls_e;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    localparam logic [5:0] OP_OR   = 6'd0;
    localparam logic [5:0] OP_NAND = 6'd1;
    localparam logic [5:0] OP_NOR  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_ADD  = 6'd4;
    localparam logic [5:0] OP_SUB  = 6'd5;
    localparam logic [5:0] OP_XOR  = 6'd6;
    localparam logic [5:0] OP_SHL  = 6'd7;
    localparam logic [5:0] OP_SHR  = 6'd8;
    localparam logic [5:0] OP_ASR  = 6'd9;

    localparam logic [2:0] CC_NEVER = 3'd0;
    localparam logic [2:0] CC_EQZ   = 3'd1;
    localparam logic [2:0] CC_LTZ   = 3'd2;
    localparam logic [2:0] CC_LEZ   = 3'd3;
    localparam logic [2:0] CC_ALWAYS = 3'd4;
    localparam logic [2:0] CC_NEZ   = 3'd5;
    localparam logic [2:0] CC_GEZ   = 3'd6;
    localparam logic [2:0] CC_GTZ   = 3'd7;

    localparam logic [2:0] REG_IO = 3'd7;

endpackage

// File: rtl/prelude_alu.sv
// Combinational ALU (r1 op r2) and branch-condition evaluator on r3.
// Shifts by DATA_W or more saturate to zero / sign fill.
module prelude_alu
    import prelude_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] cval,
    input  logic [2:0]        cc,
    output logic [DATA_W-1:0] result,
    output logic              cond_true
);

    logic                     shift_big;
    logic signed [DATA_W-1:0] a_s;
    logic [DATA_W-1:0]        asr_v;
    logic                     zero;
    logic                     neg;

    always_comb begin
        shift_big = 32'(b) >= 32'(DATA_W);
        a_s       = a;
        asr_v     = a_s >>> b;
        result    = '0;
        unique case (op)
            OP_OR:   result = a | b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_AND:  result = a & b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = shift_big ? '0 : (a << b);
            OP_SHR:  result = shift_big ? '0 : (a >> b);
            OP_ASR:  result = shift_big ? {DATA_W{a[DATA_W-1]}} : asr_v;
            default: result = '0;
        endcase
    end

    always_comb begin
        zero      = (cval == '0);
        neg       = cval[DATA_W-1];
        cond_true = 1'b0;
        unique case (cc)
            CC_NEVER:  cond_true = 1'b0;
            CC_EQZ:    cond_true = zero;
            CC_LTZ:    cond_true = neg;
            CC_LEZ:    cond_true = neg | zero;
            CC_ALWAYS: cond_true = 1'b1;
            CC_NEZ:    cond_true = ~zero;
            CC_GEZ:    cond_true = ~neg;
            CC_GTZ:    cond_true = ~neg & ~zero;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/prelude_core.sv
// Prelude CPU: two-state fetch/exec FSM, r0..r6 register file,
// r7 mapped to a valid/ready input stream and 1-entry output buffer.
module prelude_core
    import prelude_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    input  logic [DATA_W-1:0] io_in,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic              retire
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [7];
    logic [DATA_W-1:0] regs_d [7];
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              io_out_valid_q, io_out_valid_d;
    logic              retire_q, retire_d;

    cls_e              cls;
    logic [2:0]        src;
    logic [2:0]        dst;
    logic              src_io;
    logic              dst_io;
    logic              is_exec;
    logic              in_ok;
    logic              out_ok;
    logic              done;
    logic [DATA_W-1:0] copy_val;
    logic [DATA_W-1:0] alu_res;
    logic              cond_true;

    prelude_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a        (regs_q[1]),
        .b        (regs_q[2]),
        .op       (ir_q[5:0]),
        .cval     (regs_q[3]),
        .cc       (ir_q[2:0]),
        .result   (alu_res),
        .cond_true(cond_true)
    );

    always_comb begin
        cls     = cls_e'(ir_q[7:6]);
        src     = ir_q[5:3];
        dst     = ir_q[2:0];
        src_io  = (src == REG_IO);
        dst_io  = (dst == REG_IO);
        is_exec = (state_q == ST_EXEC);
        in_ok   = ~src_io | io_in_valid;
        out_ok  = ~dst_io | ~io_out_valid_q | io_out_ready;
        done    = is_exec & ((cls != CLS_COPY) | (in_ok & out_ok));
        // a 7->7 copy only pulls input when the output can take it
        io_in_ready = is_exec & (cls == CLS_COPY) & src_io & out_ok;
        copy_val    = '0;
        if (src_io) begin
            copy_val = io_in;
        end else begin
            copy_val = regs_q[src];
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        regs_d         = regs_q;
        io_out_d       = io_out_q;
        io_out_valid_d = io_out_valid_q;
        retire_d       = 1'b0;

        if (io_out_valid_q && io_out_ready) begin
            io_out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (done) begin
                    state_d  = ST_FETCH;
                    retire_d = 1'b1;
                    pc_d     = pc_q + ADDR_W'(1);
                    unique case (cls)
                        CLS_IMM:  regs_d[0] = DATA_W'(ir_q[5:0]);
                        CLS_CALC: regs_d[3] = alu_res;
                        CLS_COPY: begin
                            if (dst_io) begin
                                io_out_d       = copy_val;
                                io_out_valid_d = 1'b1;
                            end else begin
                                regs_d[dst] = copy_val;
                            end
                        end
                        CLS_BRANCH: begin
                            if (cond_true) begin
                                pc_d = ADDR_W'(regs_q[0]);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_FETCH;
            pc_q           <= RESET_PC;
            ir_q           <= '0;
            regs_q         <= '{default: '0};
            io_out_q       <= '0;
            io_out_valid_q <= 1'b0;
            retire_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            regs_q         <= regs_d;
            io_out_q       <= io_out_d;
            io_out_valid_q <= io_out_valid_d;
            retire_q       <= retire_d;
        end
    end

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign io_out       = io_out_q;
    assign io_out_valid = io_out_valid_q;
    assign retire       = retire_q;

endmodule

// File: tb/tb_prelude_core.sv
// Testbench for prelude_core (DATA_W=16, ADDR_W=4): directed scenarios
// plus a random program checked against a behavioural instruction model.
module tb_prelude_core;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [7:0]    imem_data = 8'h00;
    logic [DW-1:0] io_in = '0;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [DW-1:0] io_out;
    logic          io_out_valid;
    logic          io_out_ready = 1'b0;
    logic          retire;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] m_r [7];
    int            m_pc;
    logic [DW-1:0] exp_out [$];
    logic [DW-1:0] sunk [$];
    int            retire_cnt = 0;

    logic [AW-1:0] r_addr;
    logic          r_held;
    int            r_wret;
    int            r_cyc;
    int            r_rdy;

    always #5 clk = ~clk;

    prelude_core #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RESET_PC(4'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .io_in       (io_in),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_out      (io_out),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .retire      (retire)
    );

    // Sink side: record every output transfer and every retire pulse.
    always @(negedge clk) begin
        #3;
        if (reset === 1'b1 && io_out_valid === 1'b1 && io_out_ready === 1'b1)
            sunk.push_back(io_out);
        if (reset === 1'b1 && retire === 1'b1)
            retire_cnt++;
    end

    function automatic logic [DW-1:0] alu_ref(logic [DW-1:0] a, logic [DW-1:0] b, int op);
        longint ua = longint'(a);
        longint ub = longint'(b);
        int     sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        case (op)
            0: return a | b;
            1: return ~(a & b);
            2: return ~(a | b);
            3: return a & b;
            4: return 16'(ua + ub);
            5: return 16'(ua - ub);
            6: return a ^ b;
            7: return (ub >= 16) ? 16'h0 : 16'(ua * (longint'(1) << ub));
            8: return (ub >= 16) ? 16'h0 : 16'(ua / (longint'(1) << ub));
            9: begin
                if (ub >= 16) return (sa < 0) ? 16'hFFFF : 16'h0;
                return 16'(sa >>> ub);
            end
            default: return 16'h0;
        endcase
    endfunction

    function automatic bit cond_ref(logic [DW-1:0] v, int cc);
        int s = (v >= 16'h8000) ? -1 : ((v == 0) ? 0 : 1);
        case (cc)
            0: return 1'b0;
            1: return s == 0;
            2: return s < 0;
            3: return s <= 0;
            4: return 1'b1;
            5: return s != 0;
            6: return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 7; i++) m_r[i] = '0;
        m_pc = 0;
        exp_out.delete();
    endfunction

    function automatic void model_step(logic [7:0] ins, logic [DW-1:0] din);
        int src = int'(ins[5:3]);
        int dst = int'(ins[2:0]);
        logic [DW-1:0] v;
        case (ins[7:6])
            2'b00: begin m_r[0] = 16'(ins[5:0]); m_pc = (m_pc + 1) % 16; end
            2'b01: begin m_r[3] = alu_ref(m_r[1], m_r[2], int'(ins[5:0])); m_pc = (m_pc + 1) % 16; end
            2'b10: begin
                if (src == 7) v = din;
                else v = m_r[src];
                if (dst == 7) exp_out.push_back(v);
                else m_r[dst] = v;
                m_pc = (m_pc + 1) % 16;
            end
            default: begin
                if (cond_ref(m_r[3], dst)) m_pc = int'(m_r[0]) % 16;
                else m_pc = (m_pc + 1) % 16;
            end
        endcase
    endfunction

    task automatic do_reset();
        imem_ack = 1'b0;
        io_in_valid = 1'b0;
        io_out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        sunk.delete();
        retire_cnt = 0;
    endtask

    task automatic run_instr(input logic [7:0] ins, input int ack_wait, input int in_delay,
                             input logic [DW-1:0] din, input int out_release);
        int   n;
        logic xfer;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        r_addr = imem_addr;
        r_held = 1'b1;
        r_wret = 0;
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (imem_addr !== r_addr || imem_req !== 1'b1) r_held = 1'b0;
            if (retire === 1'b1) r_wret++;
        end
        imem_data = ins;
        imem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_data = 8'($urandom);
        r_cyc = 0;
        r_rdy = 0;
        while (retire !== 1'b1 && r_cyc < 50) begin
            if (r_cyc == in_delay) begin
                io_in = din;
                io_in_valid = 1'b1;
            end
            if (r_cyc == out_release) io_out_ready = 1'b1;
            #1;
            if (io_in_ready === 1'b1) r_rdy++;
            xfer = io_in_valid && io_in_ready;
            @(posedge clk);
            @(negedge clk);
            if (xfer) io_in_valid = 1'b0;
            r_cyc++;
        end
        io_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rst_req: got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 4'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        vectors++; if (io_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", io_in_ready); end
        vectors++; if ({io_out_valid, io_out} !== 17'h0) begin miscompares++; $display("FAIL rst_out: got %b/%h want 0/0", io_out_valid, io_out); end
        vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL rst_retire: got %b want 0", retire); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_imm_calc();
        logic [7:0] prog [5] = '{8'h05, 8'h81, 8'h03, 8'h82, 8'h44};
        time t_prev;
        do_reset();
        t_prev = $time;
        for (int i = 0; i < 5; i++) begin
            run_instr(prog[i], 0, -1, '0, -1);
            vectors++; if (r_addr !== 4'(i)) begin miscompares++; $display("FAIL ic_addr%0d: got %h want %h", i, r_addr, 4'(i)); end
            vectors++; if (r_cyc != 1) begin miscompares++; $display("FAIL ic_cyc%0d: got %0d want 1", i, r_cyc); end
            if (i > 0) begin
                vectors++; if ($time - t_prev != 20) begin miscompares++; $display("FAIL ic_spacing%0d: got %0t want 20", i, $time - t_prev); end
            end
            t_prev = $time;
        end
        run_instr(8'h9F, 0, -1, '0, -1);
        vectors++; if (r_addr !== 4'h5) begin miscompares++; $display("FAIL ic_pc5: got %h want 5", r_addr); end
        vectors++; if ({io_out_valid, io_out} !== {1'b1, 16'h0008}) begin miscompares++; $display("FAIL ic_r3: got %b/%h want 1/0008", io_out_valid, io_out); end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        run_instr(8'h01, 0, -1, '0, -1);
        run_instr(8'h02, 0, -1, '0, -1);
        run_instr(8'h03, 3, -1, '0, -1);
        vectors++; if (r_addr !== 4'h2) begin miscompares++; $display("FAIL fw_addr: got %h want 2", r_addr); end
        vectors++; if (r_held !== 1'b1) begin miscompares++; $display("FAIL fw_held: got %b want 1", r_held); end
        vectors++; if (r_wret != 0) begin miscompares++; $display("FAIL fw_retire: got %0d want 0", r_wret); end
        vectors++; if (r_cyc != 1) begin miscompares++; $display("FAIL fw_cyc: got %0d want 1", r_cyc); end
        run_instr(8'h87, 0, -1, '0, -1);
        vectors++; if (r_addr !== 4'h3) begin miscompares++; $display("FAIL fw_next: got %h want 3", r_addr); end
        vectors++; if (io_out !== 16'h0003) begin miscompares++; $display("FAIL fw_r0: got %h want 0003", io_out); end
    endtask

    task automatic test_branch();
        logic [7:0]    prog [8] = '{8'h42, 8'h0A, 8'hC2, 8'hC7, 8'h0F, 8'hC4, 8'h00, 8'h9F};
        logic [AW-1:0] addrs [8] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'hB, 4'hC, 4'hF, 4'h0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_instr(prog[i], 0, -1, '0, -1);
            vectors++; if (r_addr !== addrs[i]) begin miscompares++; $display("FAIL br_addr%0d: got %h want %h", i, r_addr, addrs[i]); end
        end
        vectors++; if (io_out !== 16'hFFFF) begin miscompares++; $display("FAIL br_r3: got %h want FFFF", io_out); end
    endtask

    task automatic test_input_stall();
        do_reset();
        run_instr(8'hB8, 0, 4, 16'h1234, -1);
        vectors++; if (r_rdy != 5) begin miscompares++; $display("FAIL in_ready_cycles: got %0d want 5", r_rdy); end
        vectors++; if (r_cyc != 5) begin miscompares++; $display("FAIL in_cyc: got %0d want 5", r_cyc); end
        #4;
        vectors++; if (retire_cnt != 1) begin miscompares++; $display("FAIL in_retires: got %0d want 1", retire_cnt); end
        vectors++; if (io_in_ready !== 1'b0) begin miscompares++; $display("FAIL in_ready_idle: got %b want 0", io_in_ready); end
        @(negedge clk);
        run_instr(8'h87, 0, -1, '0, -1);
        vectors++; if ({io_out_valid, io_out} !== {1'b1, 16'h1234}) begin miscompares++; $display("FAIL in_r0: got %b/%h want 1/1234", io_out_valid, io_out); end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_instr(8'h11, 0, -1, '0, -1);
        run_instr(8'h87, 0, -1, '0, -1);
        run_instr(8'h22, 0, -1, '0, -1);
        vectors++; if ({io_out_valid, io_out} !== {1'b1, 16'h0011}) begin miscompares++; $display("FAIL bp_hold: got %b/%h want 1/0011", io_out_valid, io_out); end
        run_instr(8'h87, 0, -1, '0, 3);
        io_out_ready = 1'b0;
        vectors++; if (r_cyc != 4) begin miscompares++; $display("FAIL bp_stall: got %0d want 4", r_cyc); end
        vectors++; if ({io_out_valid, io_out} !== {1'b1, 16'h0022}) begin miscompares++; $display("FAIL bp_refill: got %b/%h want 1/0022", io_out_valid, io_out); end
        #4;
        vectors++; if (sunk.size() != 1) begin miscompares++; $display("FAIL bp_drain_n: got %0d want 1", sunk.size()); end
        else begin
            vectors++; if (sunk[0] !== 16'h0011) begin miscompares++; $display("FAIL bp_drain0: got %h want 0011", sunk[0]); end
        end
        @(negedge clk);
        io_out_ready = 1'b1;
        run_instr(8'h05, 2, -1, '0, -1);
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_fetch_drain: got %b want 0", io_out_valid); end
        vectors++; if (sunk.size() != 2) begin miscompares++; $display("FAIL bp_drain_n2: got %0d want 2", sunk.size()); end
        else begin
            vectors++; if (sunk[1] !== 16'h0022) begin miscompares++; $display("FAIL bp_drain1: got %h want 0022", sunk[1]); end
        end
        io_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        run_instr(8'h07, 0, -1, '0, -1);
        run_instr(8'h87, 0, -1, '0, -1);
        run_instr(8'h05, 0, -1, '0, -1);
        imem_data = 8'hB8;
        imem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++; if (io_in_ready !== 1'b1) begin miscompares++; $display("FAIL rs_stalled: got %b want 1", io_in_ready); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (imem_addr !== 4'h0) begin miscompares++; $display("FAIL rs_pc: got %h want 0", imem_addr); end
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL rs_outv: got %b want 0", io_out_valid); end
        vectors++; if ({imem_req, io_in_ready, retire} !== 3'b100) begin miscompares++; $display("FAIL rs_ctl: got %b want 100", {imem_req, io_in_ready, retire}); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_instr(8'h87, 0, -1, '0, -1);
        vectors++; if (r_addr !== 4'h0) begin miscompares++; $display("FAIL rs_first_fetch: got %h want 0", r_addr); end
        vectors++; if ({io_out_valid, io_out} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL rs_r0: got %b/%h want 1/0000", io_out_valid, io_out); end
    endtask

    task automatic test_random();
        logic [7:0]    ins;
        logic [DW-1:0] din;
        int            in_delay;
        int            exp_cyc;
        do_reset();
        io_out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: ins = {2'b00, 6'($urandom)};
                1: ins = {2'b01, ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9))};
                2: ins = {2'b10, 6'($urandom)};
                default: ins = {2'b11, 6'($urandom)};
            endcase
            din = 16'($urandom);
            in_delay = (ins[7:6] == 2'b10 && ins[5:3] == 3'd7) ? int'($urandom_range(0, 2)) : -1;
            exp_cyc = (in_delay >= 0) ? in_delay + 1 : 1;
            run_instr(ins, int'($urandom_range(0, 2)), in_delay, din, -1);
            vectors++; if (r_addr !== 4'(m_pc)) begin miscompares++; $display("FAIL rnd_pc%0d: got %h want %h (ins %h)", i, r_addr, 4'(m_pc), ins); end
            vectors++; if (r_cyc != exp_cyc) begin miscompares++; $display("FAIL rnd_cyc%0d: got %0d want %0d (ins %h)", i, r_cyc, exp_cyc, ins); end
            model_step(ins, din);
        end
        repeat (3) @(negedge clk);
        #4;
        vectors++; if (sunk.size() != exp_out.size()) begin miscompares++; $display("FAIL rnd_out_n: got %0d want %0d", sunk.size(), exp_out.size()); end
        for (int i = 0; i < exp_out.size() && i < sunk.size(); i++) begin
            vectors++; if (sunk[i] !== exp_out[i]) begin miscompares++; $display("FAIL rnd_out%0d: got %h want %h", i, sunk[i], exp_out[i]); end
        end
        @(negedge clk);
        io_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_imm_calc();
        test_fetch_wait();
        test_branch();
        test_input_stall();
        test_backpressure();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prelude_core.md
Name: prelude_core

Overview:
- Parametrised next-generation Prelude CPU. Same 8-bit instruction encoding and 8-register model as the current core.
- Data path is DATA_W wide and the program counter is ADDR_W wide.
- Instruction fetch uses a req/ack handshake to external instruction memory, so multi-cycle ROM/RAM is supported.
- Register 7 becomes a flow-controlled I/O channel: a valid/ready input stream and a 1-entry buffered output stream.

Parameters:
- DATA_W, 8, datapath/register width; legal range 8..32.
- ADDR_W, 8, PC and instruction-address width; legal range 4..16.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- imem_req  out  1  fetch request; high for the whole FETCH state
- imem_addr  out  ADDR_W  fetch address, equal to pc
- imem_ack  in  1  fetch data valid this cycle; ignored when imem_req=0
- imem_data  in  8  instruction word, sampled when imem_req&imem_ack
- io_in  in  DATA_W  input stream data
- io_in_valid  in  1  input stream valid
- io_in_ready  out  1  input consumed this cycle (combinational)
- io_out  out  DATA_W  output buffer data
- io_out_valid  out  1  output buffer full
- io_out_ready  in  1  sink accepts io_out this cycle
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (async, while reset=0):
  - pc=RESET_PC; r0..r6=0; ir=0; state=FETCH.
  - io_out=0, io_out_valid=0, retire=0.
  - imem_req=1 immediately; io_in_ready=0.
  - Reset mid-fetch or mid-stall discards the instruction; no partial writes.
- FSM states: FETCH, EXEC.
  - FETCH: imem_req=1. On imem_ack, ir<=imem_data and go to EXEC. Without ack, stay; pc and imem_addr stable.
  - EXEC: complete the instruction if it is not stalled. On completion: retire=1 (registered, asserted the following cycle), update pc, go to FETCH. If stalled, stay in EXEC with no state change.
- Throughput: 2 cycles per instruction with imem_ack tied high; +1 cycle per ack wait cycle.
- Instruction encoding:
  - 00iiiiii: r0 <= zero-extend(imm6).
  - 01oooooo: r3 <= alu(r1, r2, op).
  - 10sssddd: r[ddd] <= r[sss].
  - 11xxxccc: if cond(ccc, r3) then pc <= r0[ADDR_W-1:0], else pc+1.
- ALU ops (modulo 2^DATA_W):
  - 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB, 6 XOR.
  - 7 SHL: a<<b; result 0 if b>=DATA_W.
  - 8 SHR: logical; result 0 if b>=DATA_W.
  - 9 ASR: arithmetic; if b>=DATA_W, fills with the sign bit.
  - 10..63: result 0.
- Conditions use r3 and its sign bit r3[DATA_W-1]:
  - 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
- Non-branch instructions: pc <= pc+1, wrapping modulo 2^ADDR_W.
- Register 7 as input (copy with sss=7):
  - io_in_ready=1 in EXEC while this instruction is pending.
  - Stall until io_in_valid. Transfer happens when valid&ready.
  - io_in_ready is 0 in every other case.
- Register 7 as output (copy with ddd=7):
  - Write allowed if io_out_valid=0, or if io_out_ready=1 in the same cycle (drain and refill same edge; valid stays 1). Otherwise stall.
  - io_out holds its value while valid&!ready.
  - Drain: io_out_valid<=0 on valid&ready when there is no refill.
  - Draining is independent of CPU state and continues during FETCH.
- Copy 7->7: both conditions must hold in the same cycle; transfers input to output.
- Copy with dst=r0..r6 and src=r7 reads the input stream, never the output buffer.
- r7 never appears as an ALU or branch operand, since those decode to fixed registers r0..r3.

Decomposition:
- prelude_pkg:
  - class enum (IMM/CALC/COPY/BRANCH)
  - ALU op constants
  - condition constants
  - FSM state enum
  - REG_IO=3'd7
- One sub-module: prelude_alu, parametrised by DATA_W; purely combinational ALU plus the condition evaluator.
- Register file, FSM and I/O buffer stay in prelude_core.

Test Plan:
- Reset then imm/calc, ack tied 1, DATA_W=16: program 00000101, 10000001, 00000011, 10000010, 01000100 -> r3=0x0008; retire pulses every 2 cycles; pc=5.
- Fetch wait states: ack delayed 3 cycles on pc=2 -> imem_addr held at 2; no retire for those cycles; state correct afterwards.
- Branch: r3=0xFFFF, r0=0x0A, instr 11000010 (BLT) -> pc=0x0A. Same with 11000111 (BGT) -> pc=old+1. With ADDR_W=4, pc 0xF +1 -> 0x0.
- Input stall: instr 10111000 with io_in_valid=0 for 4 cycles, then 0x1234 -> io_in_ready high 5 cycles; r0=0x1234 after transfer; single retire.
- Output backpressure: two back-to-back writes to r7 (0x11, 0x22) with io_out_ready=0 -> second write stalls; raising ready drains 0x11 and loads 0x22 on the same edge; valid stays 1.
- Async reset asserted mid-EXEC stall -> outputs clear without a clock edge; pc=RESET_PC; io_out_valid=0; after release, the first fetch is at RESET_PC.
